// File: rtl/mbist_mem_scheduler.sv
// Shares one pmbist engine across MEM_NUM memories. Enabled memories are tested one at a
// time in ascending index order, with a sticky fail/timeout map and a per-run watchdog.
module mbist_mem_scheduler #(
    parameter int unsigned MEM_NUM   = 4,
    parameter int unsigned MEM_ID_W  = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1,
    parameter int unsigned TIMEOUT_W = 12
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [MEM_NUM-1:0]  i_mem_en,
    output logic                o_eng_start,
    input  logic                i_eng_run,
    input  logic                i_eng_end,
    input  logic [MEM_NUM-1:0]  i_fail_flags,
    output logic [MEM_NUM-1:0]  o_mem_sel,
    output logic [MEM_ID_W-1:0] o_mem_id,
    output logic [MEM_NUM-1:0]  o_fail_map,
    output logic [MEM_NUM-1:0]  o_timeout_map,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StLaunch,
        StWaitRun,
        StRun,
        StNext,
        StDone
    } state_e;

    localparam logic [MEM_ID_W-1:0] LastIdx = MEM_ID_W'(MEM_NUM - 1);

    state_e               state_q, state_d;
    logic [MEM_ID_W-1:0]  idx_q, idx_d;
    logic [MEM_NUM-1:0]   en_q, en_d;
    logic [MEM_NUM-1:0]   fail_q, fail_d;
    logic [MEM_NUM-1:0]   tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

    logic                 found;
    logic [MEM_ID_W-1:0]  found_idx;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic                 wdog_expired;

    // Lowest enabled memory at or above the current index.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = 0; i < MEM_NUM; i++) begin
            if (!found && en_q[i] && (i >= int'(idx_q))) begin
                found     = 1'b1;
                found_idx = MEM_ID_W'(i);
            end
        end
    end

    assign wdog_inc     = wdog_q + TIMEOUT_W'(1);
    assign wdog_expired = &wdog_inc;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = en_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        wdog_d  = wdog_q;

        if (i_abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        en_d    = i_mem_en;
                        fail_d  = '0;
                        tmo_d   = '0;
                        idx_d   = '0;
                        wdog_d  = '0;
                        state_d = StScan;
                    end
                end
                StScan: begin
                    if (found) begin
                        idx_d   = found_idx;
                        state_d = StLaunch;
                    end else begin
                        state_d = StDone;
                    end
                end
                StLaunch: begin
                    wdog_d  = '0;
                    state_d = StWaitRun;
                end
                StWaitRun, StRun: begin
                    fail_d[idx_q] = fail_q[idx_q] | i_fail_flags[idx_q];
                    wdog_d        = wdog_inc;
                    // Watchdog expiry outranks a coincident end-of-program.
                    if (wdog_expired) begin
                        tmo_d[idx_q]  = 1'b1;
                        fail_d[idx_q] = 1'b1;
                        state_d       = StNext;
                    end else if (state_q == StWaitRun && i_eng_run) begin
                        state_d = StRun;
                    end else if (state_q == StRun && i_eng_end) begin
                        state_d = StNext;
                    end
                end
                StNext: begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + MEM_ID_W'(1);
                        state_d = StScan;
                    end
                end
                StDone: begin
                    if (!i_start) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            en_q    <= '0;
            fail_q  <= '0;
            tmo_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        o_mem_sel = '0;
        if (state_q inside {StLaunch, StWaitRun, StRun}) o_mem_sel[idx_q] = 1'b1;
    end

    assign o_eng_start   = (state_q == StLaunch);
    assign o_mem_id      = idx_q;
    assign o_fail_map    = fail_q;
    assign o_timeout_map = tmo_q;
    assign o_busy        = (state_q != StIdle) && (state_q != StDone);
    assign o_done        = (state_q == StDone);

endmodule

// File: tb/tb_mbist_mem_scheduler.sv
// Randomized scoreboard bench for mbist_mem_scheduler: a reactive engine model drives the
// handshake, a reference model predicts launches, end maps and cycle timing.
module tb_mbist_mem_scheduler;

    localparam int MEM_NUM = 4;
    localparam int TW      = 4;
    localparam int LAST    = (1 << TW) - 2;  // last wait/run cycle index before expiry

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         i_start = 1'b0;
    logic         i_abort = 1'b0;
    logic [3:0]   i_mem_en = '0;
    logic         o_eng_start;
    logic         i_eng_run = 1'b0;
    logic         i_eng_end = 1'b0;
    logic [3:0]   i_fail_flags = '0;
    logic [3:0]   o_mem_sel;
    logic [1:0]   o_mem_id;
    logic [3:0]   o_fail_map;
    logic [3:0]   o_timeout_map;
    logic         o_busy;
    logic         o_done;

    mbist_mem_scheduler #(
        .MEM_NUM  (MEM_NUM),
        .TIMEOUT_W(TW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_mem_en     (i_mem_en),
        .o_eng_start  (o_eng_start),
        .i_eng_run    (i_eng_run),
        .i_eng_end    (i_eng_end),
        .i_fail_flags (i_fail_flags),
        .o_mem_sel    (o_mem_sel),
        .o_mem_id     (o_mem_id),
        .o_fail_map   (o_fail_map),
        .o_timeout_map(o_timeout_map),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; int cyc; } launch_t;
    typedef struct { logic [3:0] fail; logic [3:0] tmo; int cyc; } fin_t;

    launch_t exp_launch[$];
    fin_t    exp_final[$];
    fin_t    exp_last;

    int nvec = 0;
    int nerr = 0;

    // Per-memory engine behaviour, in wait/run cycle indices counted from the cycle after launch.
    int         a_p[4];     // run rises at this index
    int         endk_p[4];  // end pulses at this index
    int         ff_p[4];    // selected fail flag pulses at this index (-1: none)
    logic [3:0] hold_mask = '0;
    bit         eng_kill = 1'b0;

    int  launch_cnt = 0;
    int  launch_id  = 0;
    int  done_cnt   = 0;
    bit  done_prev  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: each enabled memory occupies launch + min(end,LAST)+1 wait/run cycles,
    // then 2 cycles to relaunch scan or reach DONE (1 extra for SCAN unless it was the last index).
    task automatic model_run(input logic [3:0] en, input int s);
        int      l, last, n, done_c;
        launch_t lr;
        fin_t    f;
        f.fail = '0;
        f.tmo  = '0;
        l      = s + 2;
        done_c = s + 2;
        for (int m = 0; m < MEM_NUM; m++) begin
            if (en[m]) begin
                lr.id  = m;
                lr.cyc = l;
                exp_launch.push_back(lr);
                last = (endk_p[m] < LAST) ? endk_p[m] : LAST;
                if (endk_p[m] >= LAST) begin
                    f.tmo[m]  = 1'b1;
                    f.fail[m] = 1'b1;
                end
                if (ff_p[m] >= 0 && ff_p[m] <= last) f.fail[m] = 1'b1;
                n = l + 1 + last;
                done_c = (m == MEM_NUM - 1) ? n + 2 : n + 3;
                l = n + 3;
            end
        end
        f.cyc = done_c;
        exp_final.push_back(f);
        exp_last = f;
    endtask

    task automatic start_run(input logic [3:0] en, input bit hold);
        @(posedge clk);
        #1;
        i_start  = 1'b1;
        i_mem_en = en;
        model_run(en, cyc);
        @(posedge clk);
        #1;
        i_start  = hold;
        i_mem_en = 4'($urandom);
    endtask

    task automatic wait_done(input int tgt);
        int n = 0;
        while (done_cnt < tgt && n < 600) begin
            @(posedge clk);
            n++;
        end
        chk("done_reached", 32'(done_cnt), 32'(tgt));
    endtask

    task automatic wait_launch(input int tgt);
        int n = 0;
        while (launch_cnt < tgt && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("launch_reached", 32'(launch_cnt), 32'(tgt));
    endtask

    task automatic set_all(input int a, input int endk, input int ff);
        for (int m = 0; m < MEM_NUM; m++) begin
            a_p[m]    = a;
            endk_p[m] = endk;
            ff_p[m]   = ff;
        end
    endtask

    task automatic queues_empty(input string nm);
        chk({nm, "_launch_q"}, 32'(exp_launch.size()), 0);
        chk({nm, "_final_q"}, 32'(exp_final.size()), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT launches or reaches DONE.
    initial begin
        launch_t lr;
        fin_t    f;
        forever begin
            @(negedge clk);
            if (o_eng_start) begin
                launch_id = int'(o_mem_id);
                launch_cnt++;
                if (exp_launch.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_launch: mem_id %0d launched, none expected", o_mem_id);
                end else begin
                    lr = exp_launch.pop_front();
                    chk("launch_sel", 32'(o_mem_sel), 32'(1 << lr.id));
                    chk("launch_id", 32'(o_mem_id), 32'(lr.id));
                    chk("launch_cycle", cyc, lr.cyc);
                end
            end
            if (o_done && !done_prev) begin
                done_cnt++;
                if (exp_final.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_done: done rose, none expected");
                end else begin
                    f = exp_final.pop_front();
                    chk("done_fail_map", 32'(o_fail_map), 32'(f.fail));
                    chk("done_timeout_map", 32'(o_timeout_map), 32'(f.tmo));
                    chk("done_cycle", cyc, f.cyc);
                    chk("done_busy", 32'(o_busy), 0);
                end
            end
            done_prev = o_done;
        end
    end

    // Reactive engine: answers each observed launch using that memory's behaviour table.
    int   e_seen = 0;
    int   e_k    = 0;
    int   e_id   = 0;
    bit   e_act  = 1'b0;
    logic [3:0] e_flags;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (launch_cnt != e_seen) begin
                e_seen = launch_cnt;
                e_act  = 1'b1;
                e_k    = 0;
                e_id   = launch_id;
            end
            e_flags = 4'($urandom) | hold_mask;
            if (e_act && !eng_kill) begin
                i_eng_run      = (e_k >= a_p[e_id]);
                i_eng_end      = (e_k == endk_p[e_id]);
                e_flags[e_id]  = (e_k == ff_p[e_id]);
                if (e_k >= ((endk_p[e_id] < LAST) ? endk_p[e_id] : LAST)) e_act = 1'b0;
                e_k++;
            end else begin
                e_act     = 1'b0;
                i_eng_run = 1'b0;
                i_eng_end = 1'b0;
            end
            i_fail_flags = e_flags;
        end
    end

    initial begin
        int tgt, base;
        set_all(0, 10, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({o_eng_start, o_mem_sel, o_mem_id, o_fail_map, o_timeout_map,
                                  o_busy, o_done}), 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // All four memories, clean engine.
        tgt = done_cnt + 1;
        start_run(4'b1111, 1'b0);
        chk("busy_after_start", 32'(o_busy), 1);
        wait_done(tgt);
        queues_empty("all4");

        // Only 1 and 3 tested; unselected flag 0 held high must be ignored.
        set_all(0, 10, -1);
        ff_p[3]   = 5;
        hold_mask = 4'b0001;
        tgt = done_cnt + 1;
        start_run(4'b1010, 1'b0);
        wait_done(tgt);
        @(posedge clk);
        #1;
        chk("sparse_fail_map", 32'(o_fail_map), 32'(4'b1000));
        hold_mask = '0;
        queues_empty("sparse");

        // Nothing enabled: DONE two cycles after start.
        tgt = done_cnt + 1;
        start_run(4'b0000, 1'b0);
        wait_done(tgt);
        queues_empty("none");

        // Memory 2 never ends: watchdog flags it, memory 3 still runs.
        set_all(0, 10, -1);
        endk_p[2] = 99;
        tgt = done_cnt + 1;
        start_run(4'b1111, 1'b0);
        wait_done(tgt);
        @(posedge clk);
        #1;
        chk("wdog_timeout_map", 32'(o_timeout_map), 32'(4'b0100));
        chk("wdog_fail_map", 32'(o_fail_map), 32'(4'b0100));
        queues_empty("wdog");

        // Abort during RUN of memory 1; maps retained, restart clears them.
        set_all(1, 99, -1);
        endk_p[0] = 6;
        ff_p[0]   = 2;
        base = launch_cnt;
        start_run(4'b1111, 1'b0);
        wait_launch(base + 2);
        repeat (3) @(posedge clk);
        #1;
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_mem_sel", 32'(o_mem_sel), 0);
        chk("abort_done", 32'(o_done), 0);
        chk("abort_fail_map", 32'(o_fail_map), 32'(4'b0001));
        chk("abort_unlaunched", 32'(exp_launch.size()), 2);
        exp_launch.delete();
        exp_final.delete();
        eng_kill = 1'b1;
        repeat (20) @(posedge clk);
        eng_kill = 1'b0;
        set_all(0, 5, -1);
        tgt = done_cnt + 1;
        start_run(4'b1111, 1'b0);
        chk("restart_fail_clear", 32'(o_fail_map), 0);
        wait_done(tgt);
        queues_empty("restart");

        // Asynchronous reset while memory 2 is running.
        set_all(0, 10, 3);
        base = launch_cnt;
        start_run(4'b1100, 1'b0);
        wait_launch(base + 1);
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({o_eng_start, o_mem_sel, o_mem_id, o_fail_map,
                                        o_timeout_map, o_busy, o_done}), 0);
        chk("reset_unlaunched", 32'(exp_launch.size()), 1);
        exp_launch.delete();
        exp_final.delete();
        eng_kill = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (20) @(posedge clk);
        eng_kill = 1'b0;

        // Start held high through DONE must not re-run.
        set_all(0, 4, -1);
        tgt = done_cnt + 1;
        start_run(4'b0001, 1'b1);
        wait_done(tgt);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_done", 32'(o_done), 1);
        chk("hold_busy", 32'(o_busy), 0);
        i_start = 1'b0;
        @(posedge clk);
        #1;
        chk("release_done", 32'(o_done), 0);
        queues_empty("hold");
        tgt = done_cnt + 1;
        start_run(4'b0010, 1'b0);
        wait_done(tgt);
        queues_empty("rerun");

        // Randomized runs, including end/watchdog collisions and late fail flags.
        for (int it = 0; it < 30; it++) begin
            for (int m = 0; m < MEM_NUM; m++) begin
                a_p[m]    = $urandom_range(0, 3);
                endk_p[m] = ($urandom_range(0, 7) == 0) ? 99
                                                        : a_p[m] + 1 + $urandom_range(0, 14);
                ff_p[m]   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 18) : -1;
            end
            tgt = done_cnt + 1;
            start_run(4'($urandom), 1'b0);
            wait_done(tgt);
            repeat (2) @(posedge clk);
            #1;
            chk("idle_fail_held", 32'(o_fail_map), 32'(exp_last.fail));
            chk("idle_tmo_held", 32'(o_timeout_map), 32'(exp_last.tmo));
            queues_empty("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mbist_mem_scheduler.md
# mbist_mem_scheduler

Sequencer that shares one pmbist engine across `MEM_NUM` memories and tests them one at a time, in ascending index order, skipping memories that are disabled.
- For each memory it drives the one-hot memory select, pulses the engine start, and waits for end-of-program.
- It accumulates a sticky per-memory fail map and guards each run with a watchdog.
- It sits between the TDR control bits and the pmbist engine / memory wrappers.

## Interface
Parameters:
- `MEM_NUM`, default 4: number of memories sharing the engine (≥1).
- `MEM_ID_W`, default `$clog2(MEM_NUM)` (min 1): width of the memory index.
- `TIMEOUT_W`, default 12: width of the per-run watchdog counter.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `i_start`  in  1: level; a start is taken when sampled high in IDLE.
- `i_abort`  in  1: synchronous abort, highest priority.
- `i_mem_en`  in  `MEM_NUM`: per-memory test enable, sampled into `en_q` on start.
- `o_eng_start`  out  1: one-cycle start pulse to the engine.
- `i_eng_run`  in  1: engine running level.
- `i_eng_end`  in  1: engine end_of_prog (pulse or level).
- `i_fail_flags`  in  `MEM_NUM`: per-memory compare fail flags.
- `o_mem_sel`  out  `MEM_NUM`: one-hot select of the memory under test, 0 when none.
- `o_mem_id`  out  `MEM_ID_W`: index of the current memory.
- `o_fail_map`  out  `MEM_NUM`: sticky fail bit per memory.
- `o_timeout_map`  out  `MEM_NUM`: sticky watchdog-expired bit per memory.
- `o_busy`  out  1: high in every state except IDLE and DONE.
- `o_done`  out  1: high in DONE.

## Operation
States: IDLE, SCAN, LAUNCH, WAIT_RUN, RUN, NEXT, DONE.

- **IDLE:** on `i_start`=1:
  - latch `i_mem_en` into `en_q`;
  - clear `o_fail_map`, `o_timeout_map`, the index `idx` and the watchdog;
  - go to SCAN.
- **SCAN:** priority-find the lowest set bit of `en_q` at or above `idx`.
  - Found: load `idx` with it, go to LAUNCH.
  - None: go to DONE.
- **LAUNCH:** `o_eng_start`=1 for exactly this cycle. Watchdog cleared. Go to WAIT_RUN.
- **WAIT_RUN:** on `i_eng_run`=1, go to RUN.
- **RUN:** on `i_eng_end`=1, go to NEXT.
- **Fail capture:** in WAIT_RUN and RUN, `o_fail_map[idx]` |= `i_fail_flags[idx]`. Flags of unselected memories are ignored.
- **Watchdog:** increments each cycle in WAIT_RUN and RUN.
  - On reaching all-ones, set `o_timeout_map[idx]`, set `o_fail_map[idx]`, go to NEXT.
  - If the watchdog expires in the same cycle as `i_eng_end`, the watchdog wins and the timeout bit is set.
- **NEXT:**
  - If `idx`=`MEM_NUM`-1, go to DONE.
  - Else `idx`+1, go to SCAN.
  - `idx` never wraps.
- **DONE:** holds. Maps are held. Go to IDLE when `i_start`=0, so a start held high does not re-run.
- **`i_abort`=1 in any state:** next state IDLE; `o_mem_sel` = 0; maps are retained.
- **`o_mem_sel` / `o_mem_id`:** `o_mem_sel` = onehot(`idx`) in LAUNCH, WAIT_RUN and RUN, else 0. `o_mem_id` = `idx` always.
- **`i_mem_en` during a run:** ignored. Only `en_q` is used.

## Timing
- **Reset values:** state IDLE; all outputs 0; `idx`=0; `en_q`=0.
- **Start latency:** start sampled in cycle 0 (IDLE) → SCAN in cycle 1 → `o_eng_start` high in cycle 2. `o_mem_sel` is valid from cycle 2.
- **Between memories:** `i_eng_end` sampled in cycle n → NEXT in n+1, SCAN n+2, `o_eng_start` for the next memory in n+3.
- **No memories enabled:** `i_start` in cycle 0 → `o_done`=1 in cycle 2.
- **Fail flag on the end cycle:** a fail flag in the same cycle as `i_eng_end` is captured.
- **Flags after RUN:** fail flags asserted in NEXT or later are not captured.
- **Register timing:** all outputs are registered or derived only from the state and `idx` registers, with no input-to-output combinational path. The exception is `o_eng_start`, which is decoded from state.
- **Asynchronous reset mid-run:** immediate return to IDLE with all outputs 0.

## Test plan
- `MEM_NUM`=4, `i_mem_en`=4'b1111, engine model (run 1 cycle after start, end 20 cycles later, no fails) → four `o_eng_start` pulses with `o_mem_sel` 0001, 0010, 0100, 1000. Then `o_done`=1 and `o_fail_map`=0.
- `i_mem_en`=4'b1010, `i_fail_flags[3]` pulsed once mid-RUN of memory 3, `i_fail_flags[0]` held 1 throughout → only memories 1 and 3 launched; `o_fail_map`=4'b1000.
- `i_mem_en`=0 → `o_done`=1 in cycle 2 after start, with no `o_eng_start` pulse.
- Engine never asserts `i_eng_end` for memory 2, `TIMEOUT_W`=4 → after 15 cycles `o_timeout_map`=4'b0100 and `o_fail_map`=4'b0100; memory 3 is still tested.
- `i_abort` asserted during RUN of memory 1 → next cycle IDLE with `o_mem_sel`=0 and `o_busy`=0; a new start clears the maps and restarts from memory 0.
- `rstn` deasserted mid-run, `i_start` held high after DONE → all outputs 0; after DONE there is no second run until `i_start` goes low and then high again.
